// File: rtl/heatmap_stream_writer.sv
// Streams one frame of signed fixed-point node values to a pixel sink as RGB332,
// either through an 8-colour palette or a grayscale ramp, with ready/valid handshake.
module heatmap_stream_writer #(
  parameter int NUM_NODES = 64,
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 27,
  parameter int ADDR_W    = 8
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic                          write_sig,
  input  logic                          node_valid,
  input  logic [NUM_NODES*DATA_W-1:0]   node_flat,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic                          mode,
  input  logic                          write_ready,
  output logic                          write_en,
  output logic [7:0]                    write_data,
  output logic [ADDR_W-1:0]             write_addr,
  output logic                          done_write_sig,
  output logic                          start,
  output logic [15:0]                   frame_count
);

  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int CW    = DATA_W + 2;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_NODES - 1);
  localparam logic signed [CW-1:0] K_ONE = {{(CW-1){1'b0}}, 1'b1} << FRAC_W;
  localparam logic signed [CW-1:0] K2    = K_ONE <<< 1;
  localparam logic signed [CW-1:0] K4    = K_ONE <<< 2;
  localparam logic signed [CW-1:0] K6    = K4 + K2;
  localparam logic signed [CW-1:0] K8    = K_ONE <<< 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNAP  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Two extra headroom bits keep +/-8*ONE and v+8*ONE from overflowing.
  function automatic logic [7:0] colour(input logic [DATA_W-1:0] raw, input logic gray);
    logic signed [CW-1:0] v;
    logic signed [CW-1:0] sh;
    v  = CW'(signed'(raw));
    sh = (v + K8) >>> (FRAC_W - 4);
    if (gray) begin
      if (v >= K8)       colour = 8'hFF;
      else if (v < -K8)  colour = 8'h00;
      else               colour = 8'(sh);
    end else begin
      if (v >= K6)       colour = 8'hE0;
      else if (v >= K4)  colour = 8'hE8;
      else if (v >= K2)  colour = 8'hCD;
      else if (v >= 0)   colour = 8'hFF;
      else if (v >= -K2) colour = 8'h77;
      else if (v >= -K4) colour = 8'hF8;
      else if (v >= -K6) colour = 8'hE3;
      else               colour = 8'h00;
    end
  endfunction

  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_en;
  logic [7:0]                  r_data;
  logic [ADDR_W-1:0]           r_addr;
  logic                        r_done;
  logic                        r_start;
  logic [15:0]                 r_fc;
  logic [NUM_NODES*DATA_W-1:0] r_snap;
  logic [ADDR_W-1:0]           r_base;
  logic                        r_mode;

  logic [IDX_W-1:0]  w_next_idx;
  logic [DATA_W-1:0] w_next_raw;
  logic [7:0]        w_first_colour;
  logic [7:0]        w_next_colour;

  assign w_next_idx     = r_idx + IDX_W'(1);
  assign w_next_raw     = r_snap[w_next_idx*DATA_W +: DATA_W];
  assign w_first_colour = colour(node_flat[DATA_W-1:0], mode);
  assign w_next_colour  = colour(w_next_raw, r_mode);

  // Snapshot is loaded during SNAP so later node_flat changes cannot leak into the frame.
  always_ff @(posedge clk_50) begin
    if (r_state == S_SNAP && write_sig) begin
      r_snap <= node_flat;
      r_base <= base_addr;
      r_mode <= mode;
    end
  end

  // Frame sequencer with registered handshake outputs; abort outranks a transfer.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_start <= 1'b0;
      r_fc    <= 16'd0;
    end else begin
      r_done  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (write_sig && node_valid) r_state <= S_SNAP;
        end
        S_SNAP: begin
          if (!write_sig) begin
            r_state <= S_IDLE;
          end else begin
            r_idx   <= '0;
            r_en    <= 1'b1;
            r_data  <= w_first_colour;
            r_addr  <= base_addr;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!write_sig) begin
            r_en    <= 1'b0;
            r_state <= S_IDLE;
          end else if (write_ready) begin
            if (r_idx == LAST_IDX) begin
              r_en    <= 1'b0;
              r_done  <= 1'b1;
              r_start <= 1'b1;
              r_fc    <= r_fc + 16'd1;
              r_state <= S_DONE;
            end else begin
              r_idx  <= w_next_idx;
              r_data <= w_next_colour;
              r_addr <= r_base + ADDR_W'(w_next_idx);
            end
          end
        end
        S_DONE: begin
          if (!write_sig) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign write_en       = r_en;
  assign write_data     = r_data;
  assign write_addr     = r_addr;
  assign done_write_sig = r_done;
  assign start          = r_start;
  assign frame_count    = r_fc;

endmodule

// File: tb/tb_heatmap_stream_writer.sv
// Directed bench for heatmap_stream_writer: frame streaming, palette/grayscale
// mapping, address wrap, stalls, abort and mid-frame reset.
module tb_heatmap_stream_writer;

  localparam int NN = 64;
  localparam int DW = 32;

  logic              clk_50 = 1'b0;
  logic              reset;
  logic              write_sig;
  logic              node_valid;
  logic [NN*DW-1:0]  node_flat;
  logic [7:0]        base_addr;
  logic              mode;
  logic              write_ready;
  logic              write_en;
  logic [7:0]        write_data;
  logic [7:0]        write_addr;
  logic              done_write_sig;
  logic              start;
  logic [15:0]       frame_count;

  int n_vec   = 0;
  int n_err   = 0;
  int n_done  = 0;
  int n_start = 0;
  logic [7:0] q_data[$];
  logic [7:0] q_addr[$];
  logic       pend = 1'b0;
  logic [7:0] pend_data;
  logic [7:0] pend_addr;
  logic [7:0] pal_tab [8];

  heatmap_stream_writer #(.NUM_NODES(NN), .DATA_W(DW), .FRAC_W(27), .ADDR_W(8)) dut (
    .clk_50(clk_50), .reset(reset), .write_sig(write_sig), .node_valid(node_valid),
    .node_flat(node_flat), .base_addr(base_addr), .mode(mode), .write_ready(write_ready),
    .write_en(write_en), .write_data(write_data), .write_addr(write_addr),
    .done_write_sig(done_write_sig), .start(start), .frame_count(frame_count)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counting, stall stability and transfer capture, sampled on the falling edge.
  always @(negedge clk_50) begin
    if (done_write_sig === 1'b1) n_done++;
    if (start === 1'b1) n_start++;
    if (pend && write_en) begin
      chk("stall_data", 32'(write_data), 32'(pend_data));
      chk("stall_addr", 32'(write_addr), 32'(pend_addr));
    end
    pend      = write_en && !write_ready && write_sig && !reset;
    pend_data = write_data;
    pend_addr = write_addr;
    if (write_en && write_ready && write_sig && !reset) begin
      q_data.push_back(write_data);
      q_addr.push_back(write_addr);
    end
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NN; i++) node_flat[i*DW +: DW] = 32'(i) << 24;
  endtask

  function automatic logic [7:0] exp_data(input int kind, input int i);
    case (kind)
      0: begin
        if (i < 16)      return 8'hFF;
        else if (i < 32) return 8'hCD;
        else if (i < 48) return 8'hE8;
        else             return 8'hE0;
      end
      1: return 8'(128 + 2 * i);
      2: return (i < 8) ? pal_tab[i] : 8'hFF;
      3: return (i == 0) ? 8'hFF : ((i == 1) ? 8'h00 : 8'h80);
      default: return 8'h00;
    endcase
  endfunction

  task automatic wait_frame(input bit rnd, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      write_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done_write_sig) seen = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " start_with_done"}, 32'(start), 32'd1);
    write_ready = 1'b1;
    tick();
    chk({tag, " done_one_cycle"}, 32'(done_write_sig), 32'd0);
    chk({tag, " start_one_cycle"}, 32'(start), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int kind, input logic [7:0] base, input int n);
    logic [7:0] ea;
    chk({tag, " count"}, 32'(q_data.size()), 32'(n));
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      ea = base + 8'(i);
      chk({tag, " addr"}, 32'(q_addr[i]), 32'(ea));
      chk({tag, " data"}, 32'(q_data[i]), 32'(exp_data(kind, i)));
    end
  endtask

  task automatic end_frame();
    write_sig = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int d0;
    int s0;
    pal_tab     = '{8'hE0, 8'hE8, 8'hCD, 8'hFF, 8'h77, 8'hF8, 8'hE3, 8'h00};
    reset       = 1'b1;
    write_sig   = 1'b0;
    node_valid  = 1'b1;
    node_flat   = '0;
    base_addr   = 8'h00;
    mode        = 1'b0;
    write_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst write_en", 32'(write_en), 32'd0);
    chk("rst write_data", 32'(write_data), 32'd0);
    chk("rst write_addr", 32'(write_addr), 32'd0);
    chk("rst done", 32'(done_write_sig), 32'd0);
    chk("rst start", 32'(start), 32'd0);
    chk("rst frame_count", 32'(frame_count), 32'd0);

    // Ramp frame, palette, always ready; latency and DONE hold.
    set_ramp();
    q_data.delete(); q_addr.delete();
    write_sig = 1'b1;
    tick();
    chk("lat snap write_en", 32'(write_en), 32'd0);
    tick();
    chk("lat first write_en", 32'(write_en), 32'd1);
    chk("lat first addr", 32'(write_addr), 32'h00);
    chk("lat first data", 32'(write_data), 32'hFF);
    wait_frame(1'b0, "ramp_pal");
    check_frame("ramp_pal", 0, 8'h00, 64);
    chk("ramp_pal frame_count", 32'(frame_count), 32'd1);
    repeat (4) tick();
    chk("hold write_en", 32'(write_en), 32'd0);
    chk("hold frame_count", 32'(frame_count), 32'd1);
    chk("hold n_done", 32'(n_done), 32'd1);
    chk("hold n_start", 32'(n_start), 32'd1);
    end_frame();

    // Grayscale ramp, address wrap from 0xF0, random stalls.
    mode = 1'b1; base_addr = 8'hF0;
    q_data.delete(); q_addr.delete();
    write_sig = 1'b1;
    wait_frame(1'b1, "gray_wrap");
    check_frame("gray_wrap", 1, 8'hF0, 64);
    chk("gray_wrap frame_count", 32'(frame_count), 32'd2);
    end_frame();

    // Palette thresholds; node_flat scrambled after snapshot.
    node_flat = '0;
    node_flat[0*DW +: DW] = 32'h3800_0000;
    node_flat[1*DW +: DW] = 32'h2800_0000;
    node_flat[2*DW +: DW] = 32'h1800_0000;
    node_flat[3*DW +: DW] = 32'h0400_0000;
    node_flat[4*DW +: DW] = 32'hF800_0000;
    node_flat[5*DW +: DW] = 32'hE800_0000;
    node_flat[6*DW +: DW] = 32'hD800_0000;
    node_flat[7*DW +: DW] = 32'hC800_0000;
    mode = 1'b0; base_addr = 8'h10;
    q_data.delete(); q_addr.delete();
    write_sig = 1'b1;
    tick();
    tick();
    node_flat = '1;
    wait_frame(1'b0, "pal_tab");
    check_frame("pal_tab", 2, 8'h10, 64);
    end_frame();

    // Grayscale saturation and midpoint.
    node_flat = '0;
    node_flat[0*DW +: DW] = 32'h4800_0000;
    node_flat[1*DW +: DW] = 32'hB800_0000;
    mode = 1'b1; base_addr = 8'h20;
    q_data.delete(); q_addr.delete();
    write_sig = 1'b1;
    wait_frame(1'b0, "gray_sat");
    check_frame("gray_sat", 3, 8'h20, 64);
    chk("gray_sat frame_count", 32'(frame_count), 32'd4);
    end_frame();

    // Abort after ten transfers, then a full frame on reassertion.
    set_ramp();
    mode = 1'b0; base_addr = 8'h05;
    q_data.delete(); q_addr.delete();
    d0 = n_done; s0 = n_start;
    write_sig = 1'b1;
    for (int c = 0; c < 200 && q_data.size() < 10; c++) tick();
    write_sig = 1'b0;
    tick();
    chk("abort write_en", 32'(write_en), 32'd0);
    repeat (3) tick();
    chk("abort no done", 32'(n_done), 32'(d0));
    chk("abort no start", 32'(n_start), 32'(s0));
    chk("abort frame_count", 32'(frame_count), 32'd4);
    check_frame("abort", 0, 8'h05, 10);
    q_data.delete(); q_addr.delete();
    write_sig = 1'b1;
    wait_frame(1'b0, "reassert");
    check_frame("reassert", 0, 8'h05, 64);
    chk("reassert frame_count", 32'(frame_count), 32'd5);
    end_frame();

    // Reset at transfer 30; no partial frame resumes afterwards.
    mode = 1'b1; base_addr = 8'h00;
    q_data.delete(); q_addr.delete();
    write_sig = 1'b1;
    for (int c = 0; c < 200 && q_data.size() < 30; c++) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst write_en", 32'(write_en), 32'd0);
    chk("mid_rst write_data", 32'(write_data), 32'd0);
    chk("mid_rst write_addr", 32'(write_addr), 32'd0);
    chk("mid_rst done", 32'(done_write_sig), 32'd0);
    chk("mid_rst start", 32'(start), 32'd0);
    chk("mid_rst frame_count", 32'(frame_count), 32'd0);
    chk("mid_rst transfers", 32'(q_data.size()), 32'd30);
    write_sig = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst idle", 32'(write_en), 32'd0);
    q_data.delete(); q_addr.delete();
    write_sig = 1'b1;
    wait_frame(1'b0, "post_rst");
    check_frame("post_rst", 1, 8'h00, 64);
    chk("post_rst frame_count", 32'(frame_count), 32'd1);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/heatmap_stream_writer.md
HEATMAP_STREAM_WRITER -- requirements
Module: heatmap_stream_writer

Interface
REQ-001 SHALL have parameter NUM_NODES, default 64: number of node values per frame (1..256).
REQ-002 SHALL have parameter DATA_W, default 32: signed node width, two's complement.
REQ-003 SHALL have parameter FRAC_W, default 27: fractional bits of node values.
REQ-004 SHALL have parameter ADDR_W, default 8: pixel address width.
REQ-005 SHALL have port clk_50, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port write_sig, input, 1: level frame-enable from the host.
REQ-008 SHALL have port node_valid, input, 1: compute array idle, node values stable.
REQ-009 SHALL have port node_flat, input, NUM_NODES*DATA_W: node i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port base_addr, input, ADDR_W: address of node 0.
REQ-011 SHALL have port mode, input, 1: 0 = 8-colour palette, 1 = grayscale.
REQ-012 SHALL have port write_ready, input, 1: sink accepts a pixel this cycle.
REQ-013 SHALL have port write_en, output, 1: write_data/write_addr valid.
REQ-014 SHALL have port write_data, output, 8: RGB332 pixel.
REQ-015 SHALL have port write_addr, output, ADDR_W: pixel address.
REQ-016 SHALL have port done_write_sig, output, 1: one-cycle pulse, frame written.
REQ-017 SHALL have port start, output, 1: one-cycle pulse releasing the next compute step.
REQ-018 SHALL have port frame_count, output, 16: completed frames, wraps 0xFFFF->0.

Function
REQ-019 SHALL use states IDLE, SNAP, WRITE, DONE.
REQ-020 IDLE: write_sig=1 and node_valid=1 at an edge -> SNAP; else stay.
REQ-021 SNAP (one cycle): latch all NUM_NODES values, base_addr, mode; index=0 -> WRITE.
REQ-022 On entering WRITE, write_en=1 with write_data=colour(snap[0]) and write_addr=base_addr.
REQ-023 A transfer occurs at an edge with write_en=1 and write_ready=1; write_en, write_data and write_addr SHALL hold unchanged until the transfer.
REQ-024 On a transfer with index<NUM_NODES-1: index+1, new data/addr loaded the same edge, write_en stays 1 (one pixel/cycle when write_ready held high).
REQ-025 On the transfer with index=NUM_NODES-1: write_en=0; done_write_sig=1 and start=1 for exactly the next cycle; frame_count+1; -> DONE.
REQ-026 DONE: stay until write_sig=0, then -> IDLE (one frame per write_sig assertion).
REQ-027 write_addr SHALL be (base_addr + index) mod 2^ADDR_W.
REQ-028 write_sig=0 in SNAP or WRITE SHALL abort: -> IDLE next edge, write_en=0, no done_write_sig/start pulse, frame_count unchanged; abort takes priority over a simultaneous transfer.
REQ-029 node_flat changes after SNAP SHALL NOT affect the frame.
REQ-030 Palette (mode 0), signed compare, ONE=2^FRAC_W: v>=6*ONE 0xE0; >=4 0xE8; >=2 0xCD; >=0 0xFF; >=-2 0x77; >=-4 0xF8; >=-6 0xE3; else 0x00.
REQ-031 Grayscale (mode 1): v>=8*ONE -> 0xFF; v<-8*ONE -> 0x00; else bits [FRAC_W+3 -: 8] of (v+8*ONE).
REQ-032 Colour mapping SHALL be combinational from the snapshot, registered into write_data; no added latency.

Reset
REQ-033 reset=1 SHALL force IDLE, index=0, write_en=0, write_data=0, write_addr=0, done_write_sig=0, start=0, frame_count=0 at the next edge, including mid-frame.
REQ-034 After reset deasserts, a new frame SHALL need REQ-020 conditions; no partial frame resumes.

Verification
REQ-035 NUM_NODES=64, write_ready=1, node i=i*ONE/8, base_addr=0: 64 consecutive writes, addr 0..63, first write_en 2 cycles after write_sig; done_write_sig/start each high exactly 1 cycle; frame_count=1.
REQ-036 Values {7,5,3,0.5,-1,-3,-5,-7}*ONE, mode 0 -> 0xE0,0xE8,0xCD,0xFF,0x77,0xF8,0xE3,0x00; mode 1 with {9,-9,0}*ONE -> 0xFF,0x00,0x80.
REQ-037 write_ready toggled randomly: each pixel written exactly once, data/addr stable while stalled.
REQ-038 base_addr=0xF0, NUM_NODES=64: addresses 0xF0..0xFF then 0x00..0x2F.
REQ-039 write_sig dropped after 10 transfers: write_en low next cycle, no start pulse, frame_count unchanged; reassert -> full frame from addr base_addr.
REQ-040 reset at transfer 30, and write_sig held high through DONE: all outputs 0 after reset; only one frame per write_sig assertion.
